// File: rtl/mem_puf_challenge_seq.sv
// Challenge sequencer / response sampler for the memristive PUF cell.
// Each challenge bit (MSB first) becomes a +/-V_SET pulse of PULSE_LEN
// cycles, followed by SETTLE idle cycles and a one-cycle sample of g_in
// that is thresholded into the matching response bit.
module mem_puf_challenge_seq #(
    parameter int VIN_WIDTH = 16,
    parameter int G_WIDTH   = 16,
    parameter int FRAC_BITS = 8,
    parameter int CHAL_BITS = 16,
    parameter int V_SET     = 1088,
    parameter int PULSE_LEN = 4,
    parameter int SETTLE    = 2,
    parameter int G_THRESH  = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        chal_valid,
    output logic                        chal_ready,
    input  logic [CHAL_BITS-1:0]        chal,
    output logic                        vin_valid,
    output logic signed [VIN_WIDTH-1:0] vin,
    input  logic signed [G_WIDTH-1:0]   g_in,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [CHAL_BITS-1:0]        resp,
    output logic                        busy
);

    localparam int MAXC = (PULSE_LEN > SETTLE) ? PULSE_LEN : SETTLE;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = (CHAL_BITS > 1) ? $clog2(CHAL_BITS) : 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(CHAL_BITS - 1);

    // Magnitude is strictly below 2^(VIN_WIDTH-1), so -VPOS never hits the
    // most negative code.
    localparam logic signed [VIN_WIDTH-1:0] VPOS = VIN_WIDTH'(V_SET);
    localparam logic signed [VIN_WIDTH-1:0] VNEG = -VPOS;
    localparam logic signed [G_WIDTH-1:0]   G_TH = G_WIDTH'(G_THRESH);

    // Elaboration-time parameter sanity.
    if (V_SET <= 0 || V_SET >= (1 << (VIN_WIDTH - 1))) begin : g_bad_vset
        $error("V_SET out of range");
    end
    if (PULSE_LEN < 1 || SETTLE < 1 || CHAL_BITS < 2) begin : g_bad_len
        $error("PULSE_LEN/SETTLE must be >= 1, CHAL_BITS >= 2");
    end
    if (FRAC_BITS >= VIN_WIDTH) begin : g_bad_frac
        $error("FRAC_BITS must be below VIN_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cyc_cnt, cyc_cnt_nxt;
    logic [BW-1:0]        bit_idx, bit_idx_nxt;
    logic [CHAL_BITS-1:0] chal_sh, chal_sh_nxt;
    logic [CHAL_BITS-1:0] resp_sh, resp_sh_nxt;
    logic                 resp_bit;

    assign chal_ready = (state == S_IDLE);
    assign resp_bit   = (g_in >= G_TH);

    // Next-state and datapath updates for the sequencer.
    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt;
        bit_idx_nxt = bit_idx;
        chal_sh_nxt = chal_sh;
        resp_sh_nxt = resp_sh;
        case (state)
            S_IDLE: begin
                if (chal_valid) begin
                    chal_sh_nxt = chal;
                    resp_sh_nxt = '0;
                    bit_idx_nxt = '0;
                    cyc_cnt_nxt = '0;
                    state_nxt   = S_PULSE;
                end
            end
            S_PULSE: begin
                if (cyc_cnt == PULSE_LAST) begin
                    cyc_cnt_nxt = '0;
                    state_nxt   = S_SETTLE;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CW'(1);
                end
            end
            S_SETTLE: begin
                if (cyc_cnt == SETTLE_LAST) begin
                    cyc_cnt_nxt = '0;
                    state_nxt   = S_SAMPLE;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CW'(1);
                end
            end
            S_SAMPLE: begin
                resp_sh_nxt = {resp_sh[CHAL_BITS-2:0], resp_bit};
                chal_sh_nxt = {chal_sh[CHAL_BITS-2:0], 1'b0};
                bit_idx_nxt = bit_idx + BW'(1);
                state_nxt   = (bit_idx == BIT_LAST) ? S_DONE : S_PULSE;
            end
            S_DONE: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters and shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            chal_sh <= '0;
            resp_sh <= '0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            chal_sh <= chal_sh_nxt;
            resp_sh <= resp_sh_nxt;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_valid  <= 1'b0;
            vin        <= '0;
            resp_valid <= 1'b0;
            resp       <= '0;
            busy       <= 1'b0;
        end else begin
            vin_valid  <= (state_nxt == S_PULSE);
            if (state_nxt == S_PULSE)
                vin <= chal_sh_nxt[CHAL_BITS-1] ? VPOS : VNEG;
            else
                vin <= '0;
            resp_valid <= (state_nxt == S_DONE);
            if (state_nxt == S_DONE)
                resp <= resp_sh_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_mem_puf_challenge_seq.sv
// Bench for mem_puf_challenge_seq: memristor stub, directed cases and
// random challenges checked against an arithmetic reference model.
module tb_mem_puf_challenge_seq;

    localparam int VSET = 1088;
    localparam int PL   = 4;
    localparam int ST   = 2;
    localparam int PER  = PL + ST + 1;
    localparam int NB   = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               chal_valid = 1'b0;
    logic               chal_ready;
    logic [15:0]        chal = '0;
    logic               vin_valid;
    logic signed [15:0] vin;
    logic signed [15:0] g;
    logic               resp_valid;
    logic               resp_ready = 1'b0;
    logic [15:0]        resp;
    logic               busy;

    int checks   = 0;
    int failures = 0;
    int m_g      = 128;   // reference model of the stub conductance

    mem_puf_challenge_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .chal_valid (chal_valid),
        .chal_ready (chal_ready),
        .chal       (chal),
        .vin_valid  (vin_valid),
        .vin        (vin),
        .g_in       (g),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp       (resp),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memristor stub: +/-10 per pulsed clock, clipped at 0, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            g <= 16'sd128;
        else if (vin_valid) begin
            if (vin > 0)
                g <= g + 16'sd10;
            else if (vin < 0)
                g <= (g < 16'sd10) ? 16'sd0 : g - 16'sd10;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: response word for a challenge, advancing the model g.
    function automatic logic [15:0] model_resp(input logic [15:0] c);
        logic [15:0] r = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            for (int p = 0; p < PL; p++) begin
                m_g = c[k] ? m_g + 10 : m_g - 10;
                if (m_g < 0) m_g = 0;
            end
            r[k] = (m_g >= 128);
        end
        return r;
    endfunction

    // Offer a challenge, check every cycle of the sequence, then the result
    // handshake. hold = cycles resp_ready is held low in DONE.
    task automatic run_chal(input string tag, input logic [15:0] c, input int hold);
        logic [15:0] exp_r;
        int errs;
        int b, p;
        logic signed [15:0] ev;
        exp_r = model_resp(c);
        resp_ready = (hold == 0);
        chal = c;
        chal_valid = 1'b1;
        chk({tag, ":ready"}, 32'(chal_ready), 32'd1);
        tick();
        chal_valid = 1'b0;
        errs = 0;
        for (int i = 1; i <= NB * PER; i++) begin
            b  = (i - 1) / PER;
            p  = (i - 1) % PER;
            ev = (p < PL) ? (c[NB-1-b] ? 16'(VSET) : -16'(VSET)) : 16'sd0;
            if (vin_valid !== (p < PL)) errs++;
            if (vin !== ev) errs++;
            if (resp_valid !== 1'b0 || busy !== 1'b1 || chal_ready !== 1'b0) errs++;
            // A stray challenge offer mid-sequence must be ignored.
            chal_valid = (i % 13 == 0);
            chal = ~c;
            tick();
        end
        chal_valid = 1'b0;
        chk({tag, ":seq"}, 32'(errs), 32'd0);
        chk({tag, ":rvalid"}, 32'(resp_valid), 32'd1);
        chk({tag, ":resp"}, 32'(resp), 32'(exp_r));
        if (hold > 0) begin
            errs = 0;
            chal_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                if (resp_valid !== 1'b1 || resp !== exp_r || chal_ready !== 1'b0 || vin_valid !== 1'b0) errs++;
                tick();
            end
            chal_valid = 1'b0;
            chk({tag, ":hold"}, 32'(errs), 32'd0);
            resp_ready = 1'b1;
        end
        tick();
        chk({tag, ":idle"}, {29'd0, resp_valid, busy, chal_ready}, 32'b001);
        resp_ready = 1'b0;
    endtask

    initial begin
        int errs;
        logic [15:0] rc;
        // Reset held: outputs quiescent throughout.
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            #3;
            if (vin !== 16'sd0 || vin_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || resp !== 16'd0) errs++;
            @(posedge clk);
        end
        chk("rst:hold", 32'(errs), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst:outs", {busy, resp_valid, vin_valid, chal_ready, 12'd0, 16'(vin)}, {4'b0001, 28'd0});
        chk("rst:resp", 32'(resp), 32'd0);

        run_chal("ffff", 16'hFFFF, 0);

        rst_n = 1'b0; m_g = 128; #2 rst_n = 1'b1;
        run_chal("0000", 16'h0000, 0);
        rst_n = 1'b0; m_g = 128; #2 rst_n = 1'b1;
        run_chal("5555", 16'h5555, 0);
        rst_n = 1'b0; m_g = 128; #2 rst_n = 1'b1;
        run_chal("aaaa", 16'hAAAA, 0);
        // Backpressure, then an immediate follow-on challenge.
        run_chal("bp", 16'h3C5A, 20);
        run_chal("next", 16'hF00F, 0);

        // Mid-operation reset at cycle 30 of a challenge.
        chal = 16'hFFFF;
        chal_valid = 1'b1;
        tick();
        chal_valid = 1'b0;
        repeat (29) tick();
        chk("mrst:pulse", 32'(vin_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst:async", {30'd0, vin_valid, busy}, 32'd0);
        chk("mrst:vin", 32'(vin), 32'd0);
        m_g = 128;
        #3 rst_n = 1'b1;
        tick();
        chk("mrst:idle", {29'd0, resp_valid, busy, chal_ready}, 32'b001);
        run_chal("post", 16'hFFFF, 0);

        // Random challenges with random backpressure; stub state carries over.
        for (int n = 0; n < 10; n++) begin
            rc = 16'($urandom);
            run_chal($sformatf("rnd%0d", n), rc, int'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_puf_challenge_seq.md
# mem_puf_challenge_seq

Challenge sequencer and response sampler for the memristive PUF cell. It accepts a CHAL_BITS-wide challenge and converts each bit into a fixed-amplitude, fixed-length voltage pulse on the memristor model's `vin`/`vin_valid` inputs. After each pulse it samples the model's conductance `g_out` and thresholds it into one response bit. It sits directly upstream of the memristor (driving it) and downstream of it (consuming `g_out`), with a valid/ready handshake toward the challenge source and the response consumer.

## Interface
- VIN_WIDTH, 16: width of `vin` (signed, FRAC_BITS fractional).
- G_WIDTH, 16: width of `g_in` (signed).
- FRAC_BITS, 8: fractional bits of `vin`.
- CHAL_BITS, 16: challenge and response width.
- V_SET, 1088: pulse magnitude in vin units (4.25 V); must satisfy 0 < V_SET < 2^(VIN_WIDTH-1).
- PULSE_LEN, 4: cycles per pulse; must be ≥1.
- SETTLE, 2: idle cycles between pulse end and sample; must be ≥1.
- G_THRESH, 128: signed conductance threshold for the response bit.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  sequencer idle and able to accept.
- chal  in  CHAL_BITS  challenge word, applied MSB first.
- vin_valid  out  1  pulse active, to the memristor.
- vin  out  VIN_WIDTH signed  pulse voltage, to the memristor.
- g_in  in  G_WIDTH signed  conductance from the memristor `g_out`.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp  out  CHAL_BITS  response word.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, PULSE, SETTLE, SAMPLE, DONE.
  - IDLE: `chal_ready`=1. On `chal_valid && chal_ready`, latch `chal` into a shift register, clear `bit_idx` and `cyc_cnt`, and go to PULSE.
  - PULSE: `vin_valid`=1. `vin` = +V_SET if the current bit (shift register MSB) is 1, else −V_SET. Stay for PULSE_LEN cycles, then go to SETTLE.
  - SETTLE: `vin_valid`=0, `vin`=0. Stay for SETTLE cycles, then go to SAMPLE.
  - SAMPLE: one cycle. Response bit = (`g_in` ≥ G_THRESH), signed compare. Shift it into the LSB of `resp_sh`. Shift the challenge register left. Increment `bit_idx`. If `bit_idx` was CHAL_BITS−1, go to DONE; otherwise go to PULSE.
  - DONE: `resp_valid`=1 and `resp`=`resp_sh`, held stable until `resp_ready`. On `resp_valid && resp_ready`, go to IDLE.
- `vin`, `vin_valid`, `resp`, `resp_valid` and `busy` are registered outputs. `chal_ready` is decoded from the state (IDLE).
- Result mapping: challenge bit k (k = CHAL_BITS−1 first) produces `resp[k]`.
- `chal` is ignored outside IDLE. A new challenge is never queued.
- The block never drives `vin` = −2^(VIN_WIDTH−1).
- `g_in` is used unregistered, only in SAMPLE.
- Counters: `cyc_cnt` is sized for max(PULSE_LEN, SETTLE). `bit_idx` is sized for CHAL_BITS.

## Timing
- Reset values: `vin`=0, `vin_valid`=0, `resp`=0, `resp_valid`=0, `busy`=0, state IDLE (so `chal_ready`=1). Internal shift registers and counters are cleared.
- Reset asserted mid-operation aborts immediately: the pulse ends asynchronously with `vin_valid`=0 and the partial response is discarded.
- Handshake at edge T; first PULSE cycle (`vin_valid`=1) is T+1.
- Per bit: PULSE_LEN + SETTLE + 1 cycles. With defaults this is 7 cycles.
- `resp_valid` rises CHAL_BITS × (PULSE_LEN+SETTLE+1) cycles after the accept edge. With defaults this is 112.
- DONE with `resp_ready` already high: exactly 1 cycle of `resp_valid`, then IDLE. The next challenge can be accepted in the following cycle.
- `resp_ready` outside DONE is ignored.
- `g_in` sampled in SAMPLE reflects all pulse cycles, because SETTLE ≥1 covers the memristor's registered update.

## Test plan
Bench stub for the memristor: starts at g=128; each clock with `vin_valid` adds +10 when vin>0 and −10 when vin<0; clips at 0; registered output.
- Reset: hold `rst_n` low, then release -> all outputs at their reset values, `chal_ready`=1, `vin` never nonzero.
- Challenge 0xFFFF, `resp_ready`=1 -> 16 pulses of vin=+1088 × 4 cycles each. `resp_valid` at accept+112. `resp`=0xFFFF.
- Challenge 0x0000 -> vin=−1088 pulses; stub falls 88, 48, 8, 0… `resp`=0x0000.
- Challenge 0x5555 -> stub alternates 88/128 -> `resp`=0x5555. Challenge 0xAAAA -> stub alternates 168/128 -> `resp`=0xFFFF.
- Backpressure: `resp_ready`=0 for 20 cycles in DONE -> `resp`/`resp_valid` stable. `chal_valid`=1 during that wait is not accepted (`chal_ready`=0). Accept follows the cycle after the `resp` handshake.
- Reset at cycle 30 of a challenge -> `vin_valid` drops asynchronously. After release: IDLE, `resp_valid`=0. A fresh 0xFFFF challenge then completes normally.
